fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Control block that drives the fetch stage's stall, pc_src and pc_ext inputs.
- Arbitrates PC redirect sources: EX-stage branch and ID-stage jump. Merges hazard stalls and instruction-memory wait states.
- Generates pipeline flushes and supports halt/resume.
- Sits between the decode/execute hazard logic, the instruction memory and the fetch stage.

Parameters:
- PC_W, 16, width of ProgramCounter; all target ports use this width.
- FLUSH_BR, 2, pipeline registers flushed on a taken branch (IF/ID and ID/EX).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset: state clears immediately while low. Release is synchronous to clk.
- hazard_stall  in  1  load-use stall request from ID.
- br_taken  in  1  EX branch resolved taken this cycle.
- br_target  in  PC_W  branch target.
- jmp_valid  in  1  ID unconditional jump this cycle.
- jmp_target  in  PC_W  jump target.
- halt_req  in  1  level request to freeze fetch.
- resume  in  1  one-cycle pulse to leave HALT.
- imem_ready  in  1  instruction memory returned the word for the current PC this cycle.
- if_stall  out  1  to fetch stage stall.
- if_pc_src  out  1  to fetch stage pc_src.
- if_pc_ext  out  PC_W  to fetch stage pc_ext.
- flush_if_id  out  1  squash IF/ID register.
- flush_id_ex  out  1  squash ID/EX register.
- halted  out  1  sequencer in HALT.

Behaviour:
- States: RUN, WAIT_MEM, PEND, HALT. Reset state is RUN.
- Reset values: pending register 0, pend_flush 0. All outputs 0 while reset is low.
- Redirect select (combinational):
  - br_taken beats jmp_valid; the older instruction wins.
  - sel_target = br_taken ? br_target : jmp_target.
  - redirect = br_taken | jmp_valid.
- RUN:
  - redirect & imem_ready: if_pc_src=1, if_pc_ext=sel_target, if_stall=0. The fetch stage PC equals the target after this edge (latency 1). Stay in RUN.
  - redirect & !imem_ready: latch sel_target and its flush kind, if_stall=1 → PEND.
  - !redirect & !imem_ready: if_stall=1 → WAIT_MEM.
  - !redirect & hazard_stall: if_stall=1, stay in RUN.
  - Redirect overrides hazard_stall; the stalled instruction is flushed.
  - halt_req & !redirect & imem_ready: → HALT. A redirect in the same cycle wins, and halt is re-evaluated next cycle.
- WAIT_MEM:
  - if_stall=1 until imem_ready, then behave exactly as RUN for that cycle.
  - Redirect while waiting → PEND.
- PEND:
  - if_stall=1 until imem_ready.
  - On imem_ready: if_pc_src=1, if_pc_ext=pending → RUN.
  - A new br_taken while in PEND overwrites pending; a branch is always younger-correct.
  - jmp_valid in PEND is ignored; its fetch path is already squashed.
- HALT:
  - if_stall=1, if_pc_src=0, halted=1.
  - resume → RUN next cycle.
  - br_taken in HALT latches pending, and PEND is entered on resume.
- Flushes (asserted in the cycle the redirect is accepted or latched):
  - Branch: flush_if_id=1 and flush_id_ex=1.
  - Jump: flush_if_id=1 only.
  - Flushes are not repeated when pending is applied.
- Stall and pc_src:
  - if_stall=1 and if_pc_src=1 are never asserted together. Stall wins only when memory is not ready.
- Reset asserted mid-PEND or mid-HALT:
  - Pending target discarded, state → RUN, outputs 0 immediately (asynchronous).
- Width rules:
  - Targets pass through unmodified; no arithmetic on PC here.

Optional Feature:
- Macro FETCH_SEQ_PERF_EN.
- With the macro defined, the block adds three outputs:
  - stall_cnt (16-bit): counts cycles with if_stall=1.
  - redirect_cnt (16-bit): counts accepted redirects.
  - mispred_cnt (16-bit): counts branch redirects only.
- Counter rules: all counters saturate at 0xFFFF, reset to 0 and clear asynchronously.
- Without the macro: no counter ports, no counter logic; the rest of the behaviour is identical.

Test Plan:
- Reset low mid-run, then released → all outputs 0. The first edge after release has if_stall=0, if_pc_src=0.
- RUN, imem_ready=1, br_taken=1, br_target=0x0040, jmp_valid=1, jmp_target=0x0080 → same cycle: if_pc_src=1, if_pc_ext=0x0040, flush_if_id=1, flush_id_ex=1. Fetch PC is 0x0040 next cycle.
- imem_ready=0 for 3 cycles with jmp_valid=1, jmp_target=0x0010 in cycle 1 → flush_if_id=1 in cycle 1 only, if_stall=1 for 3 cycles. On the ready cycle: if_pc_src=1, if_pc_ext=0x0010.
- hazard_stall=1 and br_taken=1 (target 0x0022) together → if_stall=0, if_pc_src=1, if_pc_ext=0x0022.
- halt_req=1 → halted=1, if_stall=1. br_taken (target 0x0100) arrives in HALT; after the resume pulse and imem_ready: if_pc_ext=0x0100, if_pc_src=1.
- FETCH_SEQ_PERF_EN: drive 70000 stall cycles → stall_cnt=0xFFFF (saturated). 5 branch redirects → mispred_cnt=5.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer and its neighbours: hazard/redirect
// requests in, fetch-stage controls and flushes out.
interface fetch_sequencer_if #(
  parameter int PC_W = 16
);
  // br_taken/jmp_valid are single-cycle valid strobes with no ready return.
  // A redirect is consumed in the cycle it is presented: it is applied or
  // latched, except a jump seen in PEND/HALT, which is dropped.
  // imem_ready qualifies the fetch of the current PC.
  logic            hazard_stall;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            jmp_valid;
  logic [PC_W-1:0] jmp_target;
  logic            halt_req;
  logic            resume;
  logic            imem_ready;
  logic            if_stall;
  logic            if_pc_src;
  logic [PC_W-1:0] if_pc_ext;
  logic            flush_if_id;
  logic            flush_id_ex;
  logic            halted;

  modport master (
    output hazard_stall, br_taken, br_target, jmp_valid, jmp_target,
           halt_req, resume, imem_ready,
    input  if_stall, if_pc_src, if_pc_ext, flush_if_id, flush_id_ex, halted
  );

  modport slave (
    input  hazard_stall, br_taken, br_target, jmp_valid, jmp_target,
           halt_req, resume, imem_ready,
    output if_stall, if_pc_src, if_pc_ext, flush_if_id, flush_id_ex, halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch control: redirect arbitration, stall merging, flushes and halt/resume.
// Optional performance counters are enabled with macro FETCH_SEQ_PERF_EN.
module fetch_sequencer #(
  parameter int PC_W     = 16,
  parameter int FLUSH_BR = 2
) (
  input  logic             clk,
  input  logic             reset,
  fetch_sequencer_if.slave bus,
`ifdef FETCH_SEQ_PERF_EN
  output logic [15:0]      stall_cnt,
  output logic [15:0]      redirect_cnt,
  output logic [15:0]      mispred_cnt,
`endif
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_MEM = 2'd1,
    PEND     = 2'd2,
    HALT     = 2'd3
  } state_t;

  localparam bit BR_FLUSH_ID_EX = (FLUSH_BR >= 2);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pend_q, pend_d;
  logic            pend_v_q, pend_v_d;

  logic            redirect;
  logic [PC_W-1:0] sel_target;
  logic            stall_c, pc_src_c, fl_if_c, fl_ex_c;
  logic [PC_W-1:0] ext_c;

  // The branch is the older instruction, so it beats a same-cycle jump.
  assign redirect   = bus.br_taken | bus.jmp_valid;
  assign sel_target = bus.br_taken ? bus.br_target : bus.jmp_target;

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    stall_c  = 1'b0;
    pc_src_c = 1'b0;
    ext_c    = '0;
    fl_if_c  = 1'b0;
    fl_ex_c  = 1'b0;
    unique case (state_q)
      RUN, WAIT_MEM: begin
        if (bus.imem_ready) begin
          if (redirect) begin
            pc_src_c = 1'b1;
            ext_c    = sel_target;
            fl_if_c  = 1'b1;
            fl_ex_c  = bus.br_taken & BR_FLUSH_ID_EX;
            state_d  = RUN;
          end else begin
            stall_c = bus.hazard_stall;
            state_d = bus.halt_req ? HALT : RUN;
          end
        end else begin
          stall_c = 1'b1;
          if (redirect) begin
            pend_d   = sel_target;
            pend_v_d = 1'b1;
            fl_if_c  = 1'b1;
            fl_ex_c  = bus.br_taken & BR_FLUSH_ID_EX;
            state_d  = PEND;
          end else begin
            state_d = WAIT_MEM;
          end
        end
      end
      PEND: begin
        // A newer branch replaces the pending target; jumps are already squashed.
        if (bus.br_taken) begin
          fl_if_c = 1'b1;
          fl_ex_c = BR_FLUSH_ID_EX;
        end
        if (bus.imem_ready) begin
          pc_src_c = 1'b1;
          ext_c    = bus.br_taken ? bus.br_target : pend_q;
          pend_v_d = 1'b0;
          state_d  = RUN;
        end else begin
          stall_c = 1'b1;
          if (bus.br_taken) pend_d = bus.br_target;
        end
      end
      HALT: begin
        stall_c = 1'b1;
        if (bus.br_taken) begin
          pend_d   = bus.br_target;
          pend_v_d = 1'b1;
          fl_if_c  = 1'b1;
          fl_ex_c  = BR_FLUSH_ID_EX;
        end
        if (bus.resume) state_d = (pend_v_q | bus.br_taken) ? PEND : RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end

  // Combinational outputs are forced low while reset is held.
  assign bus.if_stall    = reset & stall_c;
  assign bus.if_pc_src   = reset & pc_src_c;
  assign bus.if_pc_ext   = reset ? ext_c : '0;
  assign bus.flush_if_id = reset & fl_if_c;
  assign bus.flush_id_ex = reset & fl_ex_c;
  assign bus.halted      = (state_q == HALT);
  assign dbg_state_o     = state_q;

`ifdef FETCH_SEQ_PERF_EN
  logic pend_br_q;
  logic is_br_c;

  // Remembers whether the pending target came from a branch for mispred_cnt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_br_q <= 1'b0;
    end else if ((state_q == RUN || state_q == WAIT_MEM) && !bus.imem_ready && redirect) begin
      pend_br_q <= bus.br_taken;
    end else if ((state_q == PEND || state_q == HALT) && bus.br_taken) begin
      pend_br_q <= 1'b1;
    end
  end

  assign is_br_c = (state_q == PEND) ? (bus.br_taken | pend_br_q) : bus.br_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt    <= '0;
      redirect_cnt <= '0;
      mispred_cnt  <= '0;
    end else begin
      if (bus.if_stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (bus.if_pc_src && redirect_cnt != 16'hFFFF) redirect_cnt <= redirect_cnt + 16'd1;
      if (bus.if_pc_src && is_br_c && mispred_cnt != 16'hFFFF) mispred_cnt <= mispred_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; covers FETCH_SEQ_PERF_EN counters when defined.
module tb_fetch_sequencer;
  localparam int PC_W = 16;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  logic [PC_W-1:0] fetch_pc;
`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] stall_cnt, redirect_cnt, mispred_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [PC_W-1:0] exp_q[$];
  logic [PC_W-1:0] got_q[$];

  fetch_sequencer_if #(.PC_W(PC_W)) bus ();

  fetch_sequencer #(.PC_W(PC_W), .FLUSH_BR(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
`ifdef FETCH_SEQ_PERF_EN
    .stall_cnt    (stall_cnt),
    .redirect_cnt (redirect_cnt),
    .mispred_cnt  (mispred_cnt),
`endif
    .dbg_state_o  (dbg_state)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Simple fetch-stage model so redirect latency can be observed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              fetch_pc <= '0;
    else if (bus.if_pc_src)  fetch_pc <= bus.if_pc_ext;
    else if (!bus.if_stall)  fetch_pc <= fetch_pc + 16'd2;
  end

  always @(negedge clk) begin
    if (bus.if_pc_src) got_q.push_back(bus.if_pc_ext);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // driver tasks
  task automatic drive(input logic rdy, input logic hz, input logic br, input logic [PC_W-1:0] bt,
                       input logic jv, input logic [PC_W-1:0] jt, input logic hr, input logic rs);
    bus.imem_ready   = rdy;
    bus.hazard_stall = hz;
    bus.br_taken     = br;
    bus.br_target    = bt;
    bus.jmp_valid    = jv;
    bus.jmp_target   = jt;
    bus.halt_req     = hr;
    bus.resume       = rs;
  endtask

  task automatic idle(input logic rdy);
    drive(rdy, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic check_ctl(input string tag, input logic st, input logic src,
                           input logic [PC_W-1:0] ext, input logic fi, input logic fe);
    check({tag, "_stall"},  bus.if_stall,    st);
    check({tag, "_pc_src"}, bus.if_pc_src,   src);
    check({tag, "_pc_ext"}, bus.if_pc_ext,   ext);
    check({tag, "_fl_ifid"}, bus.flush_if_id, fi);
    check({tag, "_fl_idex"}, bus.flush_id_ex, fe);
  endtask

  initial begin
    reset = 1'b0;
    idle(1'b1);
    repeat (2) next_cycle();
    // Outputs low while reset held, even with a branch presented.
    drive(1'b1, 1'b0, 1'b1, 16'h0040, 1'b0, '0, 1'b0, 1'b0);
    sample();
    check_ctl("in_reset", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("in_reset_halted", bus.halted, 1'b0);
    next_cycle();
    reset = 1'b1;
    idle(1'b1);
    sample();
    check_ctl("post_reset", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("post_reset_state", dbg_state, 2'd0);

    // Branch beats simultaneous jump.
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 16'h0040, 1'b1, 16'h0080, 1'b0, 1'b0);
    exp_q.push_back(16'h0040);
    sample();
    check_ctl("br_vs_jmp", 1'b0, 1'b1, 16'h0040, 1'b1, 1'b1);
    next_cycle();
    idle(1'b1);
    sample();
    check("br_fetch_pc", fetch_pc, 16'h0040);

    // Jump latched while memory is not ready for three cycles.
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 16'h0010, 1'b0, 1'b0);
    sample();
    check_ctl("jmp_wait_c1", 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    for (int i = 2; i <= 3; i++) begin
      next_cycle();
      idle(1'b0);
      sample();
      check_ctl($sformatf("jmp_wait_c%0d", i), 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      check($sformatf("jmp_wait_state%0d", i), dbg_state, 2'd2);
    end
    next_cycle();
    idle(1'b1);
    exp_q.push_back(16'h0010);
    sample();
    check_ctl("jmp_apply", 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0);
    next_cycle();
    idle(1'b1);
    sample();
    check("jmp_fetch_pc", fetch_pc, 16'h0010);

    // WAIT_MEM, then jump latched, overwritten by branch, later jump ignored.
    next_cycle();
    idle(1'b0);
    sample();
    check("wm_stall", bus.if_stall, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 16'h0050, 1'b0, 1'b0);
    sample();
    check("wm_state", dbg_state, 2'd1);
    check_ctl("wm_jmp", 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 16'h0060, 1'b0, '0, 1'b0, 1'b0);
    sample();
    check_ctl("pend_br", 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 16'h0070, 1'b0, 1'b0);
    sample();
    check_ctl("pend_jmp_ign", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    next_cycle();
    idle(1'b1);
    exp_q.push_back(16'h0060);
    sample();
    check_ctl("pend_apply", 1'b0, 1'b1, 16'h0060, 1'b0, 1'b0);

    // Redirect overrides hazard stall; hazard alone stalls.
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 16'h0022, 1'b0, '0, 1'b0, 1'b0);
    exp_q.push_back(16'h0022);
    sample();
    check_ctl("hz_br", 1'b0, 1'b1, 16'h0022, 1'b1, 1'b1);
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    sample();
    check_ctl("hz_only", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("hz_state", dbg_state, 2'd0);

    // Halt, branch latched in HALT, resume into PEND, apply.
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    sample();
    check("halt_req_halted", bus.halted, 1'b0);
    next_cycle();
    idle(1'b1);
    sample();
    check("halt_halted", bus.halted, 1'b1);
    check_ctl("halt", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 16'h0100, 1'b0, '0, 1'b0, 1'b0);
    sample();
    check_ctl("halt_br", 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    sample();
    check("resume_halted", bus.halted, 1'b1);
    check("resume_stall", bus.if_stall, 1'b1);
    next_cycle();
    idle(1'b1);
    exp_q.push_back(16'h0100);
    sample();
    check("resume_state", dbg_state, 2'd2);
    check_ctl("resume_apply", 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    check("resume_halted_clr", bus.halted, 1'b0);

    // Halt and resume with nothing pending goes straight to RUN.
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    sample();
    check("halt2_state", dbg_state, 2'd3);
    next_cycle();
    idle(1'b1);
    sample();
    check("halt2_run", dbg_state, 2'd0);
    check("halt2_stall", bus.if_stall, 1'b0);

    // Reset asserted mid-PEND discards the pending target.
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 16'h0200, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 16'h0300, 1'b0, '0, 1'b0, 1'b0);
    #1;
    check("rst_pend_state", dbg_state, 2'd2);
    reset = 1'b0;
    #1;
    check("rst_async_state", dbg_state, 2'd0);
    check_ctl("rst_async", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    next_cycle();
    reset = 1'b1;
    idle(1'b1);
    sample();
    check_ctl("rst_release", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("rst_release_state", dbg_state, 2'd0);

`ifdef FETCH_SEQ_PERF_EN
    check("perf_stall0", stall_cnt, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      drive(1'b1, 1'b0, 1'b1, 16'h0400 + 16'(i * 4), 1'b0, '0, 1'b0, 1'b0);
      exp_q.push_back(16'h0400 + 16'(i * 4));
    end
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 16'h0500, 1'b0, 1'b0);
    exp_q.push_back(16'h0500);
    next_cycle();
    idle(1'b1);
    sample();
    check("perf_mispred", mispred_cnt, 16'd5);
    check("perf_redirect", redirect_cnt, 16'd6);
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    repeat (70000) next_cycle();
    idle(1'b1);
    sample();
    check("perf_stall_sat", stall_cnt, 16'hFFFF);
`endif

    // scoreboard: every pc_src pulse must match the expected redirect order.
    next_cycle();
    check("sb_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      check("sb_target", got_q.pop_front(), exp_q.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
